// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding and default sizes for the shift-frame controller.
// Contents: shift_state_e (IDLE, SHIFT, CAPTURE, DONE), DEF_WIDTH, DEF_DIV_W.
package shift_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} shift_state_e;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV_W = 8;
endpackage

// File: rtl/bit_rate_div.sv
// bit_rate_div: loadable down-counter producing a terminal-count flag that paces serial bits.
// Ports: clk, rst (sync, active-high); i_load loads i_val; i_en counts down,
//        reloading i_val when the count reaches zero; o_tc high while the count is zero.
module bit_rate_div
    import shift_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_val,
    output logic             o_tc
);
    logic [DIV_W-1:0] r_cnt;

    assign o_tc = r_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load || (i_en && o_tc))
            r_cnt <= i_val;
        else if (i_en)
            r_cnt <= r_cnt - DIV_W'(1);
    end
endmodule

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: serializes a handshaked word MSB-first into a shift register and returns its parallel output.
// Ports: clk, rst (sync, active-high); div = bit period minus one;
//        in_valid/in_ready/in_data = input word handshake; sr_din/sr_en = serial bit and shift strobe;
//        sr_q = register parallel output; out_valid/out_ready/out_data = captured word handshake;
//        busy = any state other than IDLE.
module shift_frame_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sr_din,
    output logic             sr_en,
    input  logic [WIDTH-1:0] sr_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    shift_state_e     r_state;
    logic [WIDTH-1:0] r_word;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             w_acc;
    logic             w_tc;
    logic             w_strobe;
    logic [DIV_W-1:0] w_div_val;

    assign w_acc     = r_state == IDLE && in_valid;
    // Gated by rst so a frame cut short by reset never emits a stray shift.
    assign w_strobe  = r_state == SHIFT && w_tc && !rst;
    // The live div input only matters at acceptance; afterwards the latched copy paces the frame.
    assign w_div_val = r_state == IDLE ? div : r_div;

    bit_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .i_load(w_acc),
        .i_en  (r_state == SHIFT),
        .i_val (w_div_val),
        .o_tc  (w_tc)
    );

    assign in_ready  = r_state == IDLE;
    assign busy      = r_state != IDLE;
    assign sr_en     = w_strobe;
    // The word shifts left on each strobe, so its MSB is always the bit currently on the line.
    assign sr_din    = r_state == SHIFT && r_word[WIDTH-1];
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_word    <= in_data;
                    r_div     <= div;
                    r_bit_cnt <= '0;
                    r_state   <= SHIFT;
                end
                SHIFT: if (w_strobe) begin
                    r_word    <= r_word << 1;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(WIDTH - 1))
                        r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_out_data  <= sr_q;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb_shift_frame_ctrl: loopback bench with a cycle-count reference model and an output scoreboard.
module tb_shift_frame_ctrl;
    localparam int WIDTH = 4;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] div = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             sr_din;
    logic             sr_en;
    logic [WIDTH-1:0] sr_q = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] sb[$];
    bit               m_active = 1'b0;
    int               m_cs = 0;
    int               m_div = 0;
    logic [WIDTH-1:0] m_data = '0;

    shift_frame_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .div      (div),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sr_din   (sr_din),
        .sr_en    (sr_en),
        .sr_q     (sr_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Attached serial-in register: shifts into bit 0 toward the MSB.
    always @(posedge clk) if (sr_en) sr_q <= {sr_q[WIDTH-2:0], sr_din};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: a frame accepted at cycle 0 strobes at every multiple of (div+1)
    // up to WIDTH*(div+1), sends bit WIDTH-1-k during period k, and presents its word
    // from cycle WIDTH*(div+1)+2 until the output handshake.
    always @(negedge clk) begin
        int p, t, exp_bit;
        p = m_div + 1;
        t = p * WIDTH;
        if (rst) begin
            chk("sr_en_in_reset", int'(sr_en), 0);
            m_active = 1'b0;
            sb.delete();
        end else begin
            chk("in_ready", int'(in_ready), int'(!m_active));
            chk("busy", int'(busy), int'(m_active));
            chk("out_valid", int'(out_valid), int'(m_active && m_cs >= t + 2));
            chk("sr_en", int'(sr_en), int'(m_active && m_cs >= 1 && m_cs <= t && m_cs % p == 0));
            if (m_active && m_cs >= 1 && m_cs <= t) begin
                exp_bit = (int'(m_data) >> (WIDTH - 1 - (m_cs - 1) / p)) & 1;
                chk("sr_din", int'(sr_din), exp_bit);
            end
            if (!m_active) begin
                if (in_valid) begin
                    m_active = 1'b1;
                    m_cs     = 1;
                    m_div    = int'(div);
                    m_data   = in_data;
                    sb.push_back(in_data);
                end
            end else if (m_cs >= t + 2 && out_ready) begin
                m_active = 1'b0;
            end else begin
                m_cs++;
            end
        end
    end

    // Output monitor: every cycle a word is presented it must match the oldest accepted word.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_unexpected at %0t: got %0h with no word pending", $time, out_data);
            end else begin
                chk("out_data", int'(out_data), int'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        int  n;
        bit  ok;
        n = 0;
        while (1) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
            if (++n > 5000) begin
                timeout("accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int dv);
        in_data  = d;
        div      = DIV_W'(dv);
        in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 5000) begin
                timeout("idle");
                break;
            end
            tick();
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        tick();
        out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_sr_din", int'(sr_din), 0);
        tick();

        send(4'b1011, 0);
        wait_idle(0);
        send(4'b0110, 3);
        wait_idle(0);

        out_ready = 1'b0;
        send(4'b0011, 0);
        in_data  = 4'b1111;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            if (++n > 100) begin
                timeout("bp_out_valid");
                break;
            end
        end
        tick();
        repeat (10) tick();
        out_ready = 1'b1;
        wait_accept();
        wait_idle(0);

        send(4'b1001, 0);
        k = 0;
        n = 0;
        while (k < 2) begin
            @(negedge clk);
            if (sr_en) k++;
            if (++n > 100) begin
                timeout("mid_strobes");
                break;
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_out_valid", int'(out_valid), 0);
        chk("after_reset_in_ready", int'(in_ready), 1);
        tick();
        send(4'b0101, 0);
        wait_idle(0);

        send(4'b1101, 1);
        div = 8'd5;
        wait_idle(0);
        send(4'b0010, 5);
        wait_idle(0);

        send(4'b0001, 0);
        send(4'b1000, 0);
        send(4'b1111, 0);
        wait_idle(0);

        send(4'b1100, 255);
        wait_idle(0);

        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            wait_idle(1);
        end

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
